// File: rtl/clasif_desviador.sv
// Coffee-bean diverter: holds graded beans in a timestamped FIFO while they
// travel down the conveyor, then pulses the matching gate once each bean arrives.
// Ports: clk, rst_n, bean_valid, led_baja/media/alta, clr_counts, count_sel ->
//        gate_baja/media/alta, busy, fifo_full, err_flag, count_out.
module clasif_desviador #(
    parameter int DEPTH  = 4,
    parameter int TS_W   = 8,
    parameter int TRAVEL = 20,
    parameter int PULSE  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bean_valid,
    input  logic       led_baja,
    input  logic       led_media,
    input  logic       led_alta,
    input  logic       clr_counts,
    input  logic [1:0] count_sel,
    output logic       gate_baja,
    output logic       gate_media,
    output logic       gate_alta,
    output logic       busy,
    output logic       fifo_full,
    output logic       err_flag,
    output logic [7:0] count_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(PULSE + 1);
    localparam logic [AW:0]     FULL_OCC = (AW + 1)'(DEPTH);
    localparam logic [TS_W-1:0] TRAVEL_C = TS_W'(TRAVEL);
    localparam logic [PW-1:0]   PULSE_C  = PW'(PULSE);

    typedef enum logic {IDLE, FIRE} state_t;

    state_t state, next_state;

    logic [TS_W-1:0] now;
    logic [2:0]      fifo_g  [DEPTH];
    logic [TS_W-1:0] fifo_ts [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     occ;
    logic [PW-1:0]   pcnt;
    logic [2:0]      cur_g;
    logic [7:0]      cnt [4];

    logic [2:0]      grade;
    logic [2:0]      head_g;
    logic [TS_W-1:0] age;
    logic            onehot, empty, full;
    logic            push, pop, fire, drop;

    assign grade  = {led_alta, led_media, led_baja};
    assign onehot = (grade == 3'b001) || (grade == 3'b010) ||
                    (grade == 3'b100);
    assign empty  = (occ == '0);
    assign full   = (occ == FULL_OCC);
    assign head_g = fifo_g[rd_ptr];
    // Modular subtraction keeps the age correct across timestamp wrap.
    assign age    = now - fifo_ts[rd_ptr];

    // Full is judged on current occupancy, so a same-cycle pop never
    // makes room for the incoming bean.
    assign push = bean_valid && onehot && !full;
    assign pop  = !empty && (age == TRAVEL_C);
    assign fire = pop && (state == IDLE);
    assign drop = pop && (state == FIRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) now <= '0;
        else        now <= now + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_g[i]  <= '0;
                fifo_ts[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_g[wr_ptr]  <= grade;
                fifo_ts[wr_ptr] <= now;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Actuator FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Actuator FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fire) next_state = FIRE;
            FIRE:    if (pcnt == PULSE_C) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // pcnt numbers the gate-high cycles 1..PULSE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt  <= '0;
            cur_g <= '0;
        end else if (fire) begin
            pcnt  <= PW'(1);
            cur_g <= head_g;
        end else if (state == FIRE) begin
            pcnt  <= pcnt + 1'b1;
        end
    end

    // Actuator FSM: outputs
    always_comb begin
        {gate_alta, gate_media, gate_baja} = 3'b000;
        if (state == FIRE)
            {gate_alta, gate_media, gate_baja} = cur_g;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (clr_counts) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (fire && head_g[i] && cnt[i] != 8'hFF)
                    cnt[i] <= cnt[i] + 1'b1;
            if (drop && cnt[3] != 8'hFF)
                cnt[3] <= cnt[3] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_flag <= 1'b0;
        else if ((bean_valid && (!onehot || full)) || drop)
            err_flag <= 1'b1;
    end

    assign busy      = !empty || (state == FIRE);
    assign fifo_full = full;
    assign count_out = cnt[count_sel];

endmodule

// File: tb/tb_clasif_desviador.sv
// Bench for clasif_desviador: directed beans, expected gate pulses queued
// by the stimulus and checked by an independent gate monitor.
module tb_clasif_desviador;
    localparam int TRAVEL = 20;
    localparam int PULSE  = 5;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       bean_valid = 0;
    logic       led_baja = 0, led_media = 0, led_alta = 0;
    logic       clr_counts = 0;
    logic [1:0] count_sel = 0;
    logic       gate_baja, gate_media, gate_alta;
    logic       busy, fifo_full, err_flag;
    logic [7:0] count_out;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    logic [2:0] exp_g [$];
    int         exp_c [$];

    clasif_desviador #(
        .DEPTH(4), .TS_W(8), .TRAVEL(TRAVEL), .PULSE(PULSE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bean_valid(bean_valid),
        .led_baja(led_baja), .led_media(led_media), .led_alta(led_alta),
        .clr_counts(clr_counts), .count_sel(count_sel),
        .gate_baja(gate_baja), .gate_media(gate_media),
        .gate_alta(gate_alta), .busy(busy), .fifo_full(fifo_full),
        .err_flag(err_flag), .count_out(count_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Drive one bean for one cycle; if it should reach a gate, queue the
    // grade and the cycle in which the gate must rise.
    task automatic send(input logic [2:0] g, input bit fires);
        bean_valid = 1;
        {led_alta, led_media, led_baja} = g;
        if (fires) begin
            exp_g.push_back(g);
            exp_c.push_back(cyc + TRAVEL + 1);
        end
        tick();
        bean_valid = 0;
        {led_alta, led_media, led_baja} = 3'b000;
    endtask

    task automatic rd(input logic [1:0] sel, input int exp,
                      input string name);
        count_sel = sel;
        #1;
        check(name, count_out, exp);
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle(2);
        rst_n = 1;
        idle(1);
    endtask

    // Monitor: on each gate rise pop the expected entry; on fall verify width.
    logic [2:0] prev_g = 0;
    int         width  = 0;
    always @(negedge clk) begin
        logic [2:0] g;
        g = {gate_alta, gate_media, gate_baja};
        if (!rst_n) begin
            prev_g = 0;
            width  = 0;
        end else begin
            if (g != 0 && prev_g == 0) begin
                if (exp_g.size() == 0) begin
                    check("unexpected_gate", int'(g), 0);
                end else begin
                    check("gate_grade", int'(g), int'(exp_g.pop_front()));
                    check("gate_cycle", cyc, exp_c.pop_front());
                end
                width = 1;
            end else if (g != 0) begin
                check("gate_stable", int'(g), int'(prev_g));
                width++;
            end else if (prev_g != 0) begin
                check("gate_width", width, PULSE);
            end
            prev_g = g;
        end
    end

    initial begin
        idle(2);
        check("rst_gates", int'({gate_alta, gate_media, gate_baja}), 0);
        check("rst_busy", busy, 0);
        check("rst_full", fifo_full, 0);
        check("rst_err", err_flag, 0);
        rd(2'd0, 0, "rst_cnt");
        rst_n = 1;
        idle(2);

        // Single media bean
        send(3'b010, 1);
        check("busy_after_accept", busy, 1);
        idle(TRAVEL + PULSE);
        check("busy_single", busy, 0);
        rd(2'd1, 1, "cnt_media_single");
        rd(2'd2, 0, "cnt_alta_single");

        // Four alta beans 6 cycles apart
        for (int i = 0; i < 4; i++) begin
            send(3'b100, 1);
            idle(5);
        end
        idle(TRAVEL + PULSE);
        rd(2'd2, 4, "cnt_alta_four");
        rd(2'd3, 0, "cnt_drop_four");
        check("err_four", err_flag, 0);
        check("busy_four", busy, 0);

        clr_counts = 1;
        tick();
        clr_counts = 0;
        rd(2'd2, 0, "clr_alta");
        rd(2'd1, 0, "clr_media");

        // Illegal grade pattern
        do_reset();
        send(3'b011, 0);
        check("bad_grade_err", err_flag, 1);
        check("bad_grade_busy", busy, 0);
        idle(TRAVEL + PULSE);
        rd(2'd0, 0, "bad_cnt_baja");
        rd(2'd1, 0, "bad_cnt_media");
        rd(2'd3, 0, "bad_cnt_drop");

        // Baja then alta 3 cycles apart: alta dropped
        do_reset();
        send(3'b001, 1);
        idle(2);
        send(3'b100, 0);
        check("close_err_early", err_flag, 0);
        idle(TRAVEL + PULSE);
        rd(2'd0, 1, "close_cnt_baja");
        rd(2'd2, 0, "close_cnt_alta");
        rd(2'd3, 1, "close_cnt_drop");
        check("close_err", err_flag, 1);

        // Five consecutive beans: 5th rejected, 2-4 dropped
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("full_before", fifo_full, 0);
            send(3'b010, i == 0);
        end
        check("full_after4", fifo_full, 1);
        check("err_before5", err_flag, 0);
        send(3'b010, 0);
        check("err_after5", err_flag, 1);
        idle(TRAVEL + PULSE + 2);
        check("full_drained", fifo_full, 0);
        rd(2'd1, 1, "burst_cnt_media");
        rd(2'd3, 3, "burst_cnt_drop");

        // Saturation of the baja counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send(3'b001, 1);
            idle(5);
        end
        idle(TRAVEL + PULSE);
        rd(2'd0, 255, "sat_baja");
        check("sat_err", err_flag, 0);

        // Reset in the middle of a pulse with two beans queued
        do_reset();
        send(3'b001, 1);
        idle(11);
        send(3'b010, 0);
        send(3'b100, 0);
        idle(TRAVEL - 14 + 2);
        check("pre_reset_gate", gate_baja, 1);
        rst_n = 0;
        #1;
        check("async_gate_drop", int'({gate_alta, gate_media, gate_baja}), 0);
        check("async_busy", busy, 0);
        idle(2);
        rst_n = 1;
        idle(TRAVEL + PULSE + 10);
        rd(2'd0, 0, "post_rst_baja");
        rd(2'd1, 0, "post_rst_media");
        rd(2'd2, 0, "post_rst_alta");
        rd(2'd3, 0, "post_rst_drop");

        check("pending_expect", exp_g.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
